// File: rtl/sram1_arbiter.sv
// SRAM1 access sequencer: shares the external SRAM between the CPU data port and the VGA fetcher.
// Optional starvation guard for the CPU is enabled with `define SRAM1_STARVE_GUARD_EN.
module sram1_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
`ifdef SRAM1_STARVE_GUARD_EN
  , parameter int MAX_WAIT = 4
`endif
) (
  input  logic              clk_25MHz,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_pause,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              own_vga_q, own_vga_d;
  logic              op_we_q, op_we_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vga_ack_q, vga_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;

  logic arb_en, grant_vga, grant_cpu;

  assign arb_en = (state_q == S_IDLE) || (state_q == S_DONE);

`ifdef SRAM1_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              force_cpu, cpu_owner;

  assign cpu_owner = (state_q != S_IDLE) && !own_vga_q;
  assign force_cpu = cpu_req && (wait_q == WAIT_W'(MAX_WAIT));
  assign grant_vga = arb_en && vga_req && !force_cpu;

  always_comb begin
    wait_d = wait_q;
    if (!cpu_req || grant_cpu) begin
      wait_d = '0;
    end else if (!cpu_owner && (wait_q != WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end
`else
  assign grant_vga = arb_en && vga_req;
`endif

  assign grant_cpu = arb_en && cpu_req && !grant_vga;

  always_comb begin
    state_d     = state_q;
    own_vga_d   = own_vga_q;
    op_we_d     = op_we_q;
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    cpu_ack_d   = 1'b0;
    vga_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Requests are sampled even in DONE: a requester that sees its ack may
        // present its next access in that same cycle for back-to-back service.
        if (grant_vga || grant_cpu) begin
          state_d     = S_SETUP;
          own_vga_d   = grant_vga;
          op_we_d     = grant_cpu && cpu_we;
          sram_addr_d = grant_vga ? vga_addr : cpu_addr;
          if (grant_cpu && cpu_we) dq_o_d = cpu_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        state_d   = S_DONE;
        cpu_ack_d = !own_vga_q;
        vga_ack_d = own_vga_q;
        if (own_vga_q)     vga_rdata_d = sram_dq_i;
        else if (!op_we_q) cpu_rdata_d = sram_dq_i;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they are derived from the state being entered.
    ce_n_d  = !((state_d == S_SETUP) || (state_d == S_ACCESS));
    oe_n_d  = ce_n_d || op_we_d;
    we_n_d  = !((state_d == S_ACCESS) && op_we_d);
    dq_oe_d = !ce_n_d && op_we_d;
  end

  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      own_vga_q   <= 1'b0;
      op_we_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      sram_addr_q <= '0;
      dq_o_q      <= '0;
      cpu_ack_q   <= 1'b0;
      vga_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_vga_q   <= own_vga_d;
      op_we_q     <= op_we_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      cpu_ack_q   <= cpu_ack_d;
      vga_ack_q   <= vga_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
    end
  end

  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign cpu_ack    = cpu_ack_q;
  assign vga_ack    = vga_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vga_rdata  = vga_rdata_q;
  assign busy       = (state_q != S_IDLE);
  assign cpu_pause  = cpu_req && !cpu_ack_q;

endmodule

// File: tb/tb_sram1_arbiter.sv
// Bench for sram1_arbiter: SRAM pin model plus a transaction-level reference of grants,
// ack timing, pin phases and memory contents; directed scenarios followed by random traffic.
module tb_sram1_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
`ifdef SRAM1_STARVE_GUARD_EN
  localparam int MAX_WAIT = 4;
`endif

  logic              clk_25MHz = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_pause;
  logic              vga_req = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic              vga_ack;
  logic [DATA_W-1:0] vga_rdata;
  logic              sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, busy;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic [DATA_W-1:0] sram_dq_i;

  always #20 clk_25MHz = ~clk_25MHz;

  sram1_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_pause (cpu_pause),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_ack   (vga_ack),
    .vga_rdata (vga_rdata),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_i (sram_dq_i),
    .busy      (busy)
  );

  // Addresses used: 0x8000..0x801F and 0xC000..0xC01F, mapped onto 64 words.
  function automatic logic [15:0] init_val(logic [17:0] a);
    return a[15:0] ^ 16'h3C5A;
  endfunction
  function automatic int unsigned mem_idx(logic [17:0] a);
    return 32'({a[14], a[4:0]});
  endfunction
  function automatic logic [17:0] idx_addr(int unsigned i);
    return 18'h08000 | (i[5] ? 18'h04000 : 18'h0) | 18'(i[4:0]);
  endfunction

  logic [15:0] sram_mem [64];
  bit          mem_clear = 1'b1;

  always @(posedge clk_25MHz) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= init_val(idx_addr(i));
    end else if (!sram_ce_n && !sram_we_n) begin
      sram_mem[mem_idx(sram_addr)] <= sram_dq_o;
    end
  end

  always_comb begin
    sram_dq_i = 16'hDEAD;
    if (!sram_ce_n && !sram_oe_n) sram_dq_i = sram_mem[mem_idx(sram_addr)];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model state ----
  typedef struct { bit we; logic [17:0] addr; logic [15:0] data; } creq_t;
  creq_t             cpu_q[$];
  logic [17:0]       vga_q[$];
  logic [15:0]       mmem [logic [17:0]];
  int                cyc = 0;
  int                next_arb = 0;
  bit                t_valid = 0, t_vga = 0, t_we = 0;
  logic [17:0]       t_addr = '0;
  logic [15:0]       t_wdata = '0;
  int                t_g = 0;
  bit                exp_cpu_ack = 0, exp_vga_ack = 0;
  bit                rand_mode = 0;
`ifdef SRAM1_STARVE_GUARD_EN
  int                wait_cnt = 0;
  bit                cur_cpu_owner = 0;
`endif
  int                cpu_acks_seen = 0;
  int                cpu_ack_last = -1, vga_ack_last = -1;
  int                cpu_ack_cycs[$];
  logic [15:0]       cpu_rd_last = '0;

  function automatic logic [15:0] mread(logic [17:0] a);
    return mmem.exists(a) ? mmem[a] : init_val(a);
  endfunction

  task automatic monitor();
    int  ph;
    bit  active;
    ph          = t_valid ? (cyc - t_g) : 0;
    exp_cpu_ack = t_valid && (ph == 3) && !t_vga;
    exp_vga_ack = t_valid && (ph == 3) && t_vga;
    active      = t_valid && ((ph == 1) || (ph == 2));
`ifdef SRAM1_STARVE_GUARD_EN
    cur_cpu_owner = t_valid && !t_vga && (ph >= 1);
`endif
    check_eq("cpu_ack", cpu_ack, exp_cpu_ack);
    check_eq("vga_ack", vga_ack, exp_vga_ack);
    check_eq("busy", busy, t_valid && (ph >= 1));
    check_eq("cpu_pause", cpu_pause, cpu_req && !exp_cpu_ack);
    check_eq("ce_n", sram_ce_n, !active);
    check_eq("oe_n", sram_oe_n, !(active && !t_we));
    check_eq("we_n", sram_we_n, !(t_valid && (ph == 2) && t_we));
    check_eq("dq_oe", sram_dq_oe, active && t_we);
    if (active) check_eq("sram_addr", sram_addr, t_addr);
    if (active && t_we) check_eq("dq_o", sram_dq_o, t_wdata);
    if (t_valid && ph == 3) begin
      if (t_we)       mmem[t_addr] = t_wdata;
      else if (t_vga) check_eq("vga_rdata", vga_rdata, mread(t_addr));
      else            check_eq("cpu_rdata", cpu_rdata, mread(t_addr));
      t_valid = 0;
    end
    if (cpu_ack) begin
      cpu_ack_last = cyc;
      cpu_acks_seen++;
      cpu_ack_cycs.push_back(cyc);
      cpu_rd_last = cpu_rdata;
    end
    if (vga_ack) vga_ack_last = cyc;
  endtask

  task automatic react();
    creq_t c;
    int unsigned r;
    if (rand_mode) begin
      if (cpu_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 63);
        cpu_q.push_back('{bit'($urandom_range(0, 1)), idx_addr(r), 16'($urandom)});
      end
      if (vga_q.size() == 0 && $urandom_range(0, 2) == 0)
        vga_q.push_back(18'h0C000 | 18'($urandom_range(0, 31)));
    end
    if (cpu_req && exp_cpu_ack) cpu_req = 1'b0;
    if (!cpu_req && cpu_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
      c = cpu_q.pop_front();
      cpu_req = 1'b1; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.data;
    end
    if (vga_req && exp_vga_ack) vga_req = 1'b0;
    if (!vga_req && vga_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
      vga_req = 1'b1; vga_addr = vga_q.pop_front();
    end
  endtask

  // Grant decision for the clock edge that ends the current cycle.
  task automatic arbitrate();
    bit gc, gv, force_c;
    gc = 0; gv = 0; force_c = 0;
    if (cyc >= next_arb) begin
`ifdef SRAM1_STARVE_GUARD_EN
      force_c = cpu_req && (wait_cnt == MAX_WAIT);
`endif
      gv = vga_req && !force_c;
      gc = cpu_req && !gv;
      if (gv || gc) begin
        t_valid = 1; t_vga = gv; t_we = gc && cpu_we;
        t_addr = gv ? vga_addr : cpu_addr; t_wdata = cpu_wdata;
        t_g = cyc; next_arb = cyc + 3;
      end
    end
`ifdef SRAM1_STARVE_GUARD_EN
    if (!cpu_req || gc) wait_cnt = 0;
    else if (!cur_cpu_owner && wait_cnt < MAX_WAIT) wait_cnt++;
`endif
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk_25MHz);
      monitor();
      react();
      arbitrate();
      cyc++;
    end
  endtask

  int k, ca0;

  initial begin
    repeat (3) @(negedge clk_25MHz);
    check_eq("rst_ce_n", sram_ce_n, 1'b1);
    check_eq("rst_oe_n", sram_oe_n, 1'b1);
    check_eq("rst_we_n", sram_we_n, 1'b1);
    check_eq("rst_dq_oe", sram_dq_oe, 1'b0);
    check_eq("rst_addr", sram_addr, 18'h0);
    check_eq("rst_dq_o", sram_dq_o, 16'h0);
    check_eq("rst_acks", {cpu_ack, vga_ack}, 2'b00);
    check_eq("rst_rdata", {cpu_rdata, vga_rdata}, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    mem_clear = 1'b0;
    rst = 1'b1;
    run(4);

    // CPU write then read of the same word
    cpu_q.push_back('{1'b1, 18'h08010, 16'hA5A5});
    k = cyc; run(6);
    check_eq("wr_ack_lat", 32'(cpu_ack_last - k), 32'd3);
    cpu_q.push_back('{1'b0, 18'h08010, 16'h0000});
    k = cyc; run(6);
    check_eq("rd_ack_lat", 32'(cpu_ack_last - k), 32'd3);
    check_eq("rd_after_wr", cpu_rd_last, 16'hA5A5);

    // Simultaneous requests: VGA first, CPU immediately after
    vga_q.push_back(18'h0C000);
    cpu_q.push_back('{1'b0, 18'h08001, 16'h0000});
    k = cyc; run(9);
    check_eq("sim_vga_lat", 32'(vga_ack_last - k), 32'd3);
    check_eq("sim_cpu_lat", 32'(cpu_ack_last - k), 32'd6);

    // Continuous VGA traffic against a pending CPU read
    for (int i = 0; i < 20; i++) vga_q.push_back(18'h0C000 | 18'(i));
    cpu_q.push_back('{1'b0, 18'h08003, 16'h0000});
    ca0 = cpu_acks_seen;
    run(50);
`ifdef SRAM1_STARVE_GUARD_EN
    check_eq("starve_guard", 32'(cpu_acks_seen - ca0), 32'd1);
`else
    check_eq("starve_vga_prio", 32'(cpu_acks_seen - ca0), 32'd0);
`endif
    run(30);

    // Back-to-back CPU reads
    cpu_ack_cycs.delete();
    for (int i = 0; i < 3; i++) cpu_q.push_back('{1'b0, 18'h08000 | 18'(i), 16'h0000});
    run(14);
    check_eq("b2b_count", 32'(cpu_ack_cycs.size()), 32'd3);
    if (cpu_ack_cycs.size() == 3) begin
      check_eq("b2b_gap1", 32'(cpu_ack_cycs[1] - cpu_ack_cycs[0]), 32'd3);
      check_eq("b2b_gap2", 32'(cpu_ack_cycs[2] - cpu_ack_cycs[1]), 32'd3);
    end

    // Reset asserted during the ACCESS cycle of a write
    cpu_q.push_back('{1'b1, 18'h08005, 16'h1234});
    run(2);
    @(negedge clk_25MHz);
    check_eq("abort_we_low", sram_we_n, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("abort_ce_n", sram_ce_n, 1'b1);
    check_eq("abort_we_n", sram_we_n, 1'b1);
    check_eq("abort_oe_n", sram_oe_n, 1'b1);
    check_eq("abort_dq_oe", sram_dq_oe, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    t_valid = 0; next_arb = 0;
    cpu_req = 1'b0; vga_req = 1'b0;
    cpu_q.delete(); vga_q.delete();
`ifdef SRAM1_STARVE_GUARD_EN
    wait_cnt = 0;
`endif
    repeat (2) @(negedge clk_25MHz);
    check_eq("abort_no_ack", cpu_ack, 1'b0);
    rst = 1'b1;
    cpu_q.push_back('{1'b0, 18'h08005, 16'h0000});
    k = cyc; run(6);
    check_eq("abort_lat", 32'(cpu_ack_last - k), 32'd3);
    check_eq("abort_no_write", cpu_rd_last, init_val(18'h08005));

    // Random mixed traffic
    rand_mode = 1;
    run(3000);
    rand_mode = 0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
